// File: rtl/uart_axi_lite_bridge.sv
// UART-driven AXI-Lite initiator. Framed commands on rx become single
// 32-bit AXI-Lite reads/writes; acks or read data are returned on tx.
//   'W' a3 a2 a1 a0 d3 d2 d1 d0 -> write, reply 'K'
//   'R' a3 a2 a1 a0             -> read,  reply d3 d2 d1 d0
//   other                       -> reply '?'
// Ports: clk, resetn (async, active-low); AXI-Lite AW/W/B/AR/R initiator
// channels (o_axi_*/i_axi_*); o_busy (FSM not idle); tx/rx serial lines.
// Optional macro UART_BRIDGE_RX_TIMEOUT_EN: abandon a partial frame after
// TIMEOUT_CYCLES without a byte and reply 'T'.

// Show-ahead FIFO; head word is visible on o_rdata_c while not empty.
module uart_fifo #(
   parameter int unsigned W  = 8,
   parameter int unsigned AW = 4
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         i_wr,
   input  logic         i_rd,
   input  logic [W-1:0] i_wdata,
   output logic [W-1:0] o_rdata_c,
   output logic         o_full_c,
   output logic         o_empty_c
);
   localparam int unsigned DEPTH = 1 << AW;
   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wptr, r_rptr;
   logic         w_push, w_pop;

   assign o_empty_c = (r_wptr == r_rptr);
   assign o_full_c  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_push    = i_wr && !o_full_c;
   assign w_pop     = i_rd && !o_empty_c;
   assign o_rdata_c = r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
         if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
      end
   end
endmodule

// 8N1 UART, 16x oversampling, with RX and TX FIFOs.
module uart_unit #(
   parameter int unsigned FIFO_AW = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [10:0] i_dvsr,
   input  logic        i_rd_uart,
   input  logic        i_wr_uart,
   input  logic [7:0]  i_w_data,
   input  logic        i_rx,
   output logic        o_tx_full_c,
   output logic        o_rx_empty_c,
   output logic [7:0]  o_r_data_c,
   output logic        o_tx
);
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;

   logic [10:0] r_bcnt;
   logic        w_tick, r_rx_meta, r_rx_sync;
   ser_state_t  r_rx_st, w_rx_st_nxt, r_tx_st, w_tx_st_nxt;
   logic [3:0]  r_rx_s, w_rx_s_nxt, r_tx_s, w_tx_s_nxt;
   logic [2:0]  r_rx_n, w_rx_n_nxt, r_tx_n, w_tx_n_nxt;
   logic [7:0]  r_rx_b, w_rx_b_nxt, r_tx_b, w_tx_b_nxt, w_txf_data;
   logic        w_rx_done, w_tx_pop, w_tx_bit, w_txf_empty;

   assign w_tick = (r_bcnt == i_dvsr);

   // Receive: centre on the start bit, then sample every 16 ticks.
   always_comb begin
      w_rx_st_nxt = r_rx_st;
      w_rx_s_nxt  = r_rx_s;
      w_rx_n_nxt  = r_rx_n;
      w_rx_b_nxt  = r_rx_b;
      w_rx_done   = 1'b0;
      unique case (r_rx_st)
         S_IDLE: if (!r_rx_sync) begin w_rx_st_nxt = S_START; w_rx_s_nxt = '0; end
         S_START: if (w_tick) begin
            if (r_rx_s == 4'd7) begin
               w_rx_st_nxt = S_DATA; w_rx_s_nxt = '0; w_rx_n_nxt = '0;
            end else w_rx_s_nxt = r_rx_s + 4'd1;
         end
         S_DATA: if (w_tick) begin
            if (r_rx_s == 4'd15) begin
               w_rx_s_nxt = '0;
               w_rx_b_nxt = {r_rx_sync, r_rx_b[7:1]};
               if (r_rx_n == 3'd7) w_rx_st_nxt = S_STOP;
               else                w_rx_n_nxt  = r_rx_n + 3'd1;
            end else w_rx_s_nxt = r_rx_s + 4'd1;
         end
         S_STOP: if (w_tick) begin
            if (r_rx_s == 4'd15) begin w_rx_st_nxt = S_IDLE; w_rx_done = 1'b1; end
            else w_rx_s_nxt = r_rx_s + 4'd1;
         end
         default: w_rx_st_nxt = S_IDLE;
      endcase
   end

   // Transmit: pop one byte from the TX FIFO and shift it out LSB first.
   always_comb begin
      w_tx_st_nxt = r_tx_st;
      w_tx_s_nxt  = r_tx_s;
      w_tx_n_nxt  = r_tx_n;
      w_tx_b_nxt  = r_tx_b;
      w_tx_pop    = 1'b0;
      w_tx_bit    = 1'b1;
      unique case (r_tx_st)
         S_IDLE: if (!w_txf_empty) begin
            w_tx_pop = 1'b1; w_tx_b_nxt = w_txf_data; w_tx_st_nxt = S_START; w_tx_s_nxt = '0;
         end
         S_START: begin
            w_tx_bit = 1'b0;
            if (w_tick) begin
               if (r_tx_s == 4'd15) begin
                  w_tx_st_nxt = S_DATA; w_tx_s_nxt = '0; w_tx_n_nxt = '0;
               end else w_tx_s_nxt = r_tx_s + 4'd1;
            end
         end
         S_DATA: begin
            w_tx_bit = r_tx_b[0];
            if (w_tick) begin
               if (r_tx_s == 4'd15) begin
                  w_tx_s_nxt = '0;
                  w_tx_b_nxt = {1'b0, r_tx_b[7:1]};
                  if (r_tx_n == 3'd7) w_tx_st_nxt = S_STOP;
                  else                w_tx_n_nxt  = r_tx_n + 3'd1;
               end else w_tx_s_nxt = r_tx_s + 4'd1;
            end
         end
         S_STOP: if (w_tick) begin
            if (r_tx_s == 4'd15) w_tx_st_nxt = S_IDLE;
            else                 w_tx_s_nxt  = r_tx_s + 4'd1;
         end
         default: w_tx_st_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_bcnt <= '0;  r_rx_meta <= 1'b1; r_rx_sync <= 1'b1;
         r_rx_st <= S_IDLE; r_rx_s <= '0; r_rx_n <= '0; r_rx_b <= '0;
         r_tx_st <= S_IDLE; r_tx_s <= '0; r_tx_n <= '0; r_tx_b <= '0;
         o_tx <= 1'b1;
      end else begin
         r_bcnt <= w_tick ? 11'd0 : r_bcnt + 11'd1;
         r_rx_meta <= i_rx;  r_rx_sync <= r_rx_meta;
         r_rx_st <= w_rx_st_nxt; r_rx_s <= w_rx_s_nxt; r_rx_n <= w_rx_n_nxt; r_rx_b <= w_rx_b_nxt;
         r_tx_st <= w_tx_st_nxt; r_tx_s <= w_tx_s_nxt; r_tx_n <= w_tx_n_nxt; r_tx_b <= w_tx_b_nxt;
         o_tx <= w_tx_bit;
      end
   end

   uart_fifo #(.W(8), .AW(FIFO_AW)) u_rx_fifo (
      .clk(clk), .resetn(resetn), .i_wr(w_rx_done), .i_rd(i_rd_uart), .i_wdata(r_rx_b),
      .o_rdata_c(o_r_data_c), .o_full_c(), .o_empty_c(o_rx_empty_c));

   uart_fifo #(.W(8), .AW(FIFO_AW)) u_tx_fifo (
      .clk(clk), .resetn(resetn), .i_wr(i_wr_uart), .i_rd(w_tx_pop), .i_wdata(i_w_data),
      .o_rdata_c(w_txf_data), .o_full_c(o_tx_full_c), .o_empty_c(w_txf_empty));
endmodule

module uart_axi_lite_bridge #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned FIFO_DEPTH_BIT = 4,
   parameter logic [10:0] DVSR           = 11'd53,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                    clk,
   input  logic                    resetn,
   output logic [ADDR_WIDTH-1:0]   o_axi_awaddr,
   output logic                    o_axi_awvalid,
   input  logic                    i_axi_awready,
   output logic [DATA_WIDTH-1:0]   o_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] o_axi_wstrb,
   output logic                    o_axi_wvalid,
   input  logic                    i_axi_wready,
   input  logic                    i_axi_bvalid,
   output logic                    o_axi_bready,
   output logic [ADDR_WIDTH-1:0]   o_axi_araddr,
   output logic                    o_axi_arvalid,
   input  logic                    i_axi_arready,
   input  logic [DATA_WIDTH-1:0]   i_axi_rdata,
   input  logic                    i_axi_rvalid,
   output logic                    o_axi_rready,
   output logic                    o_busy,
   output logic                    tx,
   input  logic                    rx
);
   localparam logic [7:0] CMD_WR = 8'h57, CMD_RD = 8'h52;
   localparam logic [7:0] RSP_OK = 8'h4B, RSP_UNK = 8'h3F, RSP_TMO = 8'h54;

   typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, AXI_WR, AXI_B, AXI_AR, AXI_R, SEND} state_t;

   state_t                r_state, w_state_nxt;
   logic [1:0]            r_cnt, w_cnt_nxt;
   logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt, w_word;
   logic [ADDR_WIDTH-1:0] w_awaddr_nxt, w_araddr_nxt;
   logic [DATA_WIDTH-1:0] w_wdata_nxt;
   logic r_is_wr, w_is_wr_nxt, r_aw_done, w_aw_done_nxt, r_w_done, w_w_done_nxt;
   logic w_awvalid_nxt, w_wvalid_nxt, w_bready_nxt, w_arvalid_nxt, w_rready_nxt;
   logic w_aw_hs, w_w_hs, w_rd_uart, w_wr_uart, w_rx_empty, w_tx_full;
   logic [7:0] w_r_data;
`ifdef UART_BRIDGE_RX_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
`endif

   assign w_word      = {r_shift[23:0], w_r_data};
   assign w_aw_hs     = o_axi_awvalid && i_axi_awready;
   assign w_w_hs      = o_axi_wvalid && i_axi_wready;
   assign o_axi_wstrb = '1;

   // Command decode, AXI sequencing and reply generation.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_shift_nxt   = r_shift;
      w_is_wr_nxt   = r_is_wr;
      w_awaddr_nxt  = o_axi_awaddr;
      w_araddr_nxt  = o_axi_araddr;
      w_wdata_nxt   = o_axi_wdata;
      w_awvalid_nxt = o_axi_awvalid;
      w_wvalid_nxt  = o_axi_wvalid;
      w_bready_nxt  = o_axi_bready;
      w_arvalid_nxt = o_axi_arvalid;
      w_rready_nxt  = o_axi_rready;
      w_aw_done_nxt = r_aw_done;
      w_w_done_nxt  = r_w_done;
      w_rd_uart     = 1'b0;
      w_wr_uart     = 1'b0;
      unique case (r_state)
         IDLE: if (!w_rx_empty) begin
            w_rd_uart = 1'b1;
            w_cnt_nxt = '0;
            if (w_r_data == CMD_WR || w_r_data == CMD_RD) begin
               w_is_wr_nxt = (w_r_data == CMD_WR);
               w_state_nxt = GET_ADDR;
            end else begin
               w_shift_nxt = {RSP_UNK, 24'h0};
               w_state_nxt = SEND;
            end
         end
         GET_ADDR: if (!w_rx_empty) begin
            w_rd_uart   = 1'b1;
            w_shift_nxt = w_word;
            w_cnt_nxt   = r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
               if (r_is_wr) begin
                  w_awaddr_nxt = w_word;
                  w_state_nxt  = GET_DATA;
               end else begin
                  w_araddr_nxt  = w_word;
                  w_arvalid_nxt = 1'b1;
                  w_state_nxt   = AXI_AR;
               end
            end
         end
         GET_DATA: if (!w_rx_empty) begin
            w_rd_uart   = 1'b1;
            w_shift_nxt = w_word;
            w_cnt_nxt   = r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
               w_wdata_nxt   = w_word;
               w_awvalid_nxt = 1'b1;
               w_wvalid_nxt  = 1'b1;
               w_state_nxt   = AXI_WR;
            end
         end
         // AW and W complete independently; move on once both have.
         AXI_WR: begin
            if (w_aw_hs) begin w_awvalid_nxt = 1'b0; w_aw_done_nxt = 1'b1; end
            if (w_w_hs)  begin w_wvalid_nxt  = 1'b0; w_w_done_nxt  = 1'b1; end
            if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
               w_aw_done_nxt = 1'b0;
               w_w_done_nxt  = 1'b0;
               w_bready_nxt  = 1'b1;
               w_state_nxt   = AXI_B;
            end
         end
         AXI_B: if (i_axi_bvalid) begin
            w_bready_nxt = 1'b0;
            w_shift_nxt  = {RSP_OK, 24'h0};
            w_cnt_nxt    = '0;
            w_state_nxt  = SEND;
         end
         AXI_AR: if (i_axi_arready) begin
            w_arvalid_nxt = 1'b0;
            w_rready_nxt  = 1'b1;
            w_state_nxt   = AXI_R;
         end
         AXI_R: if (i_axi_rvalid) begin
            w_rready_nxt = 1'b0;
            w_shift_nxt  = i_axi_rdata;
            w_cnt_nxt    = 2'd3;
            w_state_nxt  = SEND;
         end
         // r_cnt holds the number of reply bytes remaining minus one.
         SEND: if (!w_tx_full) begin
            w_wr_uart   = 1'b1;
            w_shift_nxt = {r_shift[23:0], 8'h00};
            w_cnt_nxt   = r_cnt - 2'd1;
            if (r_cnt == 2'd0) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
`ifdef UART_BRIDGE_RX_TIMEOUT_EN
      // Idle-time counter runs only while a frame is partially received.
      w_tmo_nxt = '0;
      if ((r_state == GET_ADDR || r_state == GET_DATA) && w_rx_empty) begin
         if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            w_shift_nxt = {RSP_TMO, 24'h0};
            w_cnt_nxt   = '0;
            w_state_nxt = SEND;
         end else begin
            w_tmo_nxt = r_tmo + TMO_W'(1);
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;   r_cnt <= '0;   r_shift <= '0;   r_is_wr <= 1'b0;
         r_aw_done <= 1'b0; r_w_done <= 1'b0;
         o_axi_awaddr <= '0; o_axi_araddr <= '0; o_axi_wdata <= '0;
         o_axi_awvalid <= 1'b0; o_axi_wvalid <= 1'b0; o_axi_bready <= 1'b0;
         o_axi_arvalid <= 1'b0; o_axi_rready <= 1'b0; o_busy <= 1'b0;
`ifdef UART_BRIDGE_RX_TIMEOUT_EN
         r_tmo <= '0;
`endif
      end else begin
         r_state <= w_state_nxt; r_cnt <= w_cnt_nxt; r_shift <= w_shift_nxt; r_is_wr <= w_is_wr_nxt;
         r_aw_done <= w_aw_done_nxt; r_w_done <= w_w_done_nxt;
         o_axi_awaddr <= w_awaddr_nxt; o_axi_araddr <= w_araddr_nxt; o_axi_wdata <= w_wdata_nxt;
         o_axi_awvalid <= w_awvalid_nxt; o_axi_wvalid <= w_wvalid_nxt; o_axi_bready <= w_bready_nxt;
         o_axi_arvalid <= w_arvalid_nxt; o_axi_rready <= w_rready_nxt;
         o_busy <= (w_state_nxt != IDLE);
`ifdef UART_BRIDGE_RX_TIMEOUT_EN
         r_tmo <= w_tmo_nxt;
`endif
      end
   end

   uart_unit #(.FIFO_AW(FIFO_DEPTH_BIT)) u_uart (
      .clk(clk), .resetn(resetn), .i_dvsr(DVSR), .i_rd_uart(w_rd_uart), .i_wr_uart(w_wr_uart),
      .i_w_data(r_shift[31:24]), .i_rx(rx), .o_tx_full_c(w_tx_full), .o_rx_empty_c(w_rx_empty),
      .o_r_data_c(w_r_data), .o_tx(tx));
endmodule

// File: tb/tb_uart_axi_lite_bridge.sv
module tb_uart_axi_lite_bridge;
   localparam int unsigned BIT_CLKS = 16;
   localparam int unsigned TMO      = 400;

   logic        clk = 1'b0, resetn = 1'b1, rx = 1'b1, tx;
   logic [31:0] o_axi_awaddr, o_axi_wdata, o_axi_araddr;
   logic [3:0]  o_axi_wstrb;
   logic        o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_axi_arvalid, o_axi_rready, o_busy;
   logic        i_axi_awready = 1'b0, i_axi_wready = 1'b0, i_axi_bvalid = 1'b0;
   logic        i_axi_arready = 1'b0, i_axi_rvalid = 1'b0;
   logic [31:0] i_axi_rdata = '0;

   int n_cmp = 0, n_err = 0;
   int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, aw_cyc = 0, w_cyc = 0;
   logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
   logic [3:0]  cap_wstrb = '0;
   int          aw_delay = 0, b_skip = 0;
   logic        bvalid_en = 1'b1;
   logic [31:0] rdata_cfg = '0;
   logic [7:0]  tx_q [$];

   initial forever #5 clk = ~clk;

   uart_axi_lite_bridge #(.DVSR(11'd0), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .resetn(resetn),
      .o_axi_awaddr(o_axi_awaddr), .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready),
      .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb), .o_axi_wvalid(o_axi_wvalid),
      .i_axi_wready(i_axi_wready), .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready),
      .o_axi_araddr(o_axi_araddr), .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready),
      .i_axi_rdata(i_axi_rdata), .i_axi_rvalid(i_axi_rvalid), .o_axi_rready(o_axi_rready),
      .o_busy(o_busy), .tx(tx), .rx(rx));

   // Handshake monitor.
   always @(posedge clk) begin
      if (o_axi_awvalid === 1'b1) aw_cyc <= aw_cyc + 1;
      if (o_axi_wvalid === 1'b1)  w_cyc  <= w_cyc + 1;
      if (o_axi_awvalid && i_axi_awready) begin n_aw <= n_aw + 1; cap_awaddr <= o_axi_awaddr; end
      if (o_axi_wvalid && i_axi_wready) begin
         n_w <= n_w + 1; cap_wdata <= o_axi_wdata; cap_wstrb <= o_axi_wstrb;
      end
      if (o_axi_bready && i_axi_bvalid)   n_b <= n_b + 1;
      if (o_axi_arvalid && i_axi_arready) begin n_ar <= n_ar + 1; cap_araddr <= o_axi_araddr; end
      if (o_axi_rready && i_axi_rvalid)   n_r <= n_r + 1;
   end

   // Slave responder.
   initial begin : slave
      int aw_wait;
      aw_wait = 0;
      forever begin
         @(negedge clk);
         if (o_axi_awvalid === 1'b1) begin
            i_axi_awready = (aw_wait >= aw_delay);
            aw_wait++;
         end else begin
            i_axi_awready = 1'b0;
            aw_wait = 0;
         end
         i_axi_wready  = (o_axi_wvalid === 1'b1);
         i_axi_arready = (o_axi_arvalid === 1'b1);
         i_axi_bvalid  = bvalid_en && (n_aw > n_b + b_skip) && (n_w > n_b + b_skip);
         i_axi_rvalid  = (n_ar > n_r);
         i_axi_rdata   = rdata_cfg;
      end
   end

   // Serial receiver for the DUT's tx line.
   initial begin : tx_mon
      logic [7:0] b;
      forever begin
         @(negedge tx);
         repeat (BIT_CLKS / 2) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (BIT_CLKS) @(negedge clk);
            b[i] = tx;
         end
         repeat (BIT_CLKS) @(negedge clk);
         tx_q.push_back(b);
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic uart_send(input logic [7:0] b);
      rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      rx = 1'b1;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) uart_send(w[8*i +: 8]);
   endtask

   // Wait (bounded) for n reply bytes, then settle so surplus bytes show up.
   task automatic wait_tx(input int n, input int budget);
      for (int i = 0; i < budget && tx_q.size() < n; i++) @(negedge clk);
      repeat (300) @(negedge clk);
   endtask

   task automatic test_reset();
      #1 resetn = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if ({o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_axi_arvalid, o_axi_rready} !== 5'b0) begin
         n_err++; $display("FAIL reset_valids: got %b, expected 00000",
            {o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_axi_arvalid, o_axi_rready});
      end
      n_cmp++;
      if ({o_axi_awaddr, o_axi_araddr, o_axi_wdata} !== 96'h0) begin
         n_err++; $display("FAIL reset_addr_data: got %h %h %h, expected zeros",
            o_axi_awaddr, o_axi_araddr, o_axi_wdata);
      end
      n_cmp++;
      if (o_axi_wstrb !== 4'hF) begin n_err++; $display("FAIL reset_wstrb: got %h, expected f", o_axi_wstrb); end
      n_cmp++;
      if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, expected 0", o_busy); end
      n_cmp++;
      if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b, expected 1", tx); end
      resetn = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (o_busy !== 1'b0 || tx !== 1'b1) begin
         n_err++; $display("FAIL post_reset_idle: got busy=%b tx=%b, expected busy=0 tx=1", o_busy, tx);
      end
   endtask

   task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d);
      int aw0 = n_aw, w0 = n_w, b0 = n_b, ar0 = n_ar;
      logic [7:0] got;
      uart_send(8'h57); send_word(a); send_word(d);
      wait_tx(1, 3000);
      n_cmp++;
      if (tx_q.size() != 1) begin n_err++; $display("FAIL %s_reply_count: got %0d, expected 1", tag, tx_q.size()); end
      got = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
      tx_q.delete();
      n_cmp++;
      if (got !== 8'h4B) begin n_err++; $display("FAIL %s_reply: got %h, expected 4b", tag, got); end
      n_cmp++;
      if (n_aw - aw0 != 1 || n_w - w0 != 1 || n_b - b0 != 1 || n_ar != ar0) begin
         n_err++; $display("FAIL %s_handshakes: got aw=%0d w=%0d b=%0d ar=%0d, expected 1 1 1 0",
            tag, n_aw - aw0, n_w - w0, n_b - b0, n_ar - ar0);
      end
      n_cmp++;
      if (cap_awaddr !== a || cap_wdata !== d || cap_wstrb !== 4'hF) begin
         n_err++; $display("FAIL %s_payload: got addr=%h data=%h strb=%h, expected %h %h f",
            tag, cap_awaddr, cap_wdata, cap_wstrb, a, d);
      end
      n_cmp++;
      if (o_busy !== 1'b0) begin n_err++; $display("FAIL %s_busy_after: got %b, expected 0", tag, o_busy); end
   endtask

   task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] d);
      int ar0 = n_ar, r0 = n_r, aw0 = n_aw;
      logic [31:0] got;
      rdata_cfg = d;
      uart_send(8'h52); send_word(a);
      wait_tx(4, 4000);
      n_cmp++;
      if (tx_q.size() != 4) begin n_err++; $display("FAIL %s_reply_count: got %0d, expected 4", tag, tx_q.size()); end
      got = 'x;
      for (int i = 0; i < 4; i++) if (tx_q.size() > 0) got = {got[23:0], tx_q.pop_front()};
      tx_q.delete();
      n_cmp++;
      if (got !== d) begin n_err++; $display("FAIL %s_data: got %h, expected %h", tag, got, d); end
      n_cmp++;
      if (n_ar - ar0 != 1 || n_r - r0 != 1 || n_aw != aw0 || cap_araddr !== a) begin
         n_err++; $display("FAIL %s_handshakes: got ar=%0d r=%0d aw=%0d araddr=%h, expected 1 1 0 %h",
            tag, n_ar - ar0, n_r - r0, n_aw - aw0, cap_araddr, a);
      end
   endtask

   task automatic test_write();
      do_write("write", 32'h0200_2004, 32'h0000_0035);
   endtask

   task automatic test_read();
      do_read("read", 32'h0200_200C, 32'h0000_02A5);
   endtask

   task automatic test_unknown();
      int aw0 = n_aw, ar0 = n_ar;
      logic [7:0] got;
      uart_send(8'h41);
      wait_tx(1, 2000);
      n_cmp++;
      if (tx_q.size() != 1) begin n_err++; $display("FAIL unknown_reply_count: got %0d, expected 1", tx_q.size()); end
      got = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
      tx_q.delete();
      n_cmp++;
      if (got !== 8'h3F) begin n_err++; $display("FAIL unknown_reply: got %h, expected 3f", got); end
      n_cmp++;
      if (n_aw != aw0 || n_ar != ar0) begin
         n_err++; $display("FAIL unknown_axi: got aw=%0d ar=%0d, expected 0 0", n_aw - aw0, n_ar - ar0);
      end
      do_read("read_after_unknown", 32'h0200_2004, 32'h1234_5678);
   endtask

   task automatic test_backpressure();
      int awc0 = aw_cyc, wc0 = w_cyc;
      aw_delay = 3;
      do_write("bp", 32'h0000_0040, 32'hDEAD_BEEF);
      aw_delay = 0;
      n_cmp++;
      if (aw_cyc - awc0 != 4) begin n_err++; $display("FAIL bp_awvalid_cycles: got %0d, expected 4", aw_cyc - awc0); end
      n_cmp++;
      if (w_cyc - wc0 != 1) begin n_err++; $display("FAIL bp_wvalid_cycles: got %0d, expected 1", w_cyc - wc0); end
   endtask

`ifdef UART_BRIDGE_RX_TIMEOUT_EN
   task automatic test_timeout();
      int aw0 = n_aw;
      logic [7:0] got;
      uart_send(8'h57); uart_send(8'h02); uart_send(8'h00);
      wait_tx(1, 3 * TMO);
      n_cmp++;
      if (tx_q.size() != 1) begin n_err++; $display("FAIL timeout_reply_count: got %0d, expected 1", tx_q.size()); end
      got = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
      tx_q.delete();
      n_cmp++;
      if (got !== 8'h54 || n_aw != aw0) begin
         n_err++; $display("FAIL timeout_reply: got %h aw=%0d, expected 54 aw=0", got, n_aw - aw0);
      end
      do_read("read_after_timeout", 32'h0000_0010, 32'hCAFE_0010);
   endtask
`endif

   task automatic test_reset_mid();
      bvalid_en = 1'b0;
      uart_send(8'h57); send_word(32'h0200_2008); send_word(32'h0000_0055);
      for (int i = 0; i < 3000 && o_axi_bready !== 1'b1; i++) @(negedge clk);
      n_cmp++;
      if (o_axi_bready !== 1'b1 || o_busy !== 1'b1) begin
         n_err++; $display("FAIL mid_reached_axi_b: got bready=%b busy=%b, expected 1 1", o_axi_bready, o_busy);
      end
      @(negedge clk);
      resetn = 1'b0;
      #1;
      n_cmp++;
      if ({o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_axi_arvalid, o_axi_rready, o_busy} !== 6'b0) begin
         n_err++; $display("FAIL mid_reset_outputs: got %b, expected 000000",
            {o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_axi_arvalid, o_axi_rready, o_busy});
      end
      n_cmp++;
      if (o_axi_awaddr !== 32'h0 || o_axi_wdata !== 32'h0 || tx !== 1'b1) begin
         n_err++; $display("FAIL mid_reset_regs: got awaddr=%h wdata=%h tx=%b, expected 0 0 1",
            o_axi_awaddr, o_axi_wdata, tx);
      end
      b_skip = n_aw - n_b;
      bvalid_en = 1'b1;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      do_write("write_after_reset", 32'h0200_2004, 32'h0000_00A1);
   endtask

   initial begin : main
      test_reset();
      test_write();
      test_read();
      test_unknown();
      test_backpressure();
`ifdef UART_BRIDGE_RX_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
